// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the data-memory initiator: instruction codes,
// status codes, requester FSM states and decode select encodings.
package y86_pkg;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] STAT_ADR = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_e;

  typedef enum logic {
    ADDR_VALE,
    ADDR_VALA
  } addr_sel_e;

  typedef enum logic {
    WDATA_VALA,
    WDATA_VALP
  } wdata_sel_e;

endpackage

// File: rtl/dmem_decode.sv
// Combinational icode decode: whether the instruction touches data memory,
// its direction, and which operands supply the address and write data.
module dmem_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       access,
  output logic       we,
  output addr_sel_e  addr_sel,
  output wdata_sel_e wdata_sel
);

  always_comb begin
    access    = 1'b0;
    we        = 1'b0;
    addr_sel  = ADDR_VALE;
    wdata_sel = WDATA_VALA;
    unique case (icode)
      IMRMOVQ: access = 1'b1;
      IRMMOVQ, IPUSHQ: begin
        access = 1'b1;
        we     = 1'b1;
      end
      ICALL: begin
        access    = 1'b1;
        we        = 1'b1;
        wdata_sel = WDATA_VALP;
      end
      // Stack pops take their address from the old %rsp carried in valA.
      IRET, IPOPQ: begin
        access   = 1'b1;
        addr_sel = ADDR_VALA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_requester.sv
// Y86 data-memory initiator: one req/ack transaction per memory-stage
// instruction, stalling the stage until ack, address error or timeout.
//
// state | meaning
// IDLE  | waiting for start; decodes and range-checks the access
// REQ   | mem_req held, counting cycles until ack or timeout
// DONE  | one-cycle done pulse, valM/dmem_error valid
module dmem_requester
  import y86_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        stall,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          err_q, err_d;
  logic [63:0]   mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic [63:0]   valm_q, valm_d;

  logic          dec_access, dec_we;
  addr_sel_e     dec_addr_sel;
  wdata_sel_e    dec_wdata_sel;
  logic [63:0]   sel_addr, sel_wdata;
  logic          addr_oob;

  dmem_decode u_decode (
    .icode     (icode),
    .access    (dec_access),
    .we        (dec_we),
    .addr_sel  (dec_addr_sel),
    .wdata_sel (dec_wdata_sel)
  );

  assign sel_addr  = (dec_addr_sel == ADDR_VALA) ? valA : valE;
  assign sel_wdata = (dec_wdata_sel == WDATA_VALP) ? valP : valA;
  assign addr_oob  = sel_addr >= 64'(MEM_WORDS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valm_d      = valm_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = DONE;
          if (dec_access && addr_oob) begin
            err_d = 1'b1;
          end else if (dec_access) begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = dec_we;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
          end
        end
      end
      REQ: begin
        // An ack on the final counted cycle still completes cleanly.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!mem_we_q) valm_d = mem_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valm_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valm_q      <= valm_d;
      err_q       <= err_d;
    end
  end

  assign stall      = (state_q == REQ);
  assign done       = (state_q == DONE);
  assign valM       = valm_q;
  assign dmem_error = err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: directed scenarios plus randomized instructions
// checked against a transaction-level model with its own memory image.
module tb_dmem_requester;

  localparam int MEM_WORDS = 1024;
  localparam int TIMEOUT   = 16;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        stall, done, dmem_error;
  logic [63:0] valM;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  logic [63:0] resp_mem [logic [63:0]];
  logic [63:0] ref_mem  [logic [63:0]];
  logic [63:0] exp_valm;

  int          o_dc, o_rc, o_sc;
  bit          o_we, o_unst, o_err, o_da;
  logic [63:0] o_addr, o_wdata, o_valm;

  dmem_requester #(.MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .icode      (icode),
    .valE       (valE),
    .valA       (valA),
    .valP       (valP),
    .stall      (stall),
    .done       (done),
    .valM       (valM),
    .dmem_error (dmem_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return a * 64'h9E37_79B9_7F4A_7C15 + 64'd1;
  endfunction

  function automatic logic [63:0] resp_rd(input logic [63:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // 0 = no access, 1 = read, 2 = write
  function automatic int ref_kind(input logic [3:0] ic);
    case (ic)
      4'h5, 4'h9, 4'hB: return 1;
      4'h4, 4'h8, 4'hA: return 2;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_addr(input logic [3:0] ic, input logic [63:0] ve, va);
    return (ic == 4'h9 || ic == 4'hB) ? va : ve;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [3:0] ic, input logic [63:0] va, vp);
    return (ic == 4'h8) ? vp : va;
  endfunction

  function automatic logic [63:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 64'($urandom_range(0, 31));
    if (r == 6) return 64'($urandom_range(0, MEM_WORDS - 1));
    if (r == 7) return 64'(MEM_WORDS - 1);
    if (r == 8) return 64'(MEM_WORDS);
    return {32'($urandom), 32'($urandom)};
  endfunction

  // Issues one instruction, plays the memory side (ack in req cycle ack_dly,
  // 0 = never) and records what the DUT did, cycle-indexed from start.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] ve, va, vp,
                        input int ack_dly, input bit spur);
    @(negedge clk);
    start = 1'b1; icode = ic; valE = ve; valA = va; valP = vp;
    mem_ack = spur; mem_rdata = spur ? JUNK : 64'd0;
    o_dc = -1; o_rc = 0; o_sc = 0; o_unst = 0; o_we = 0;
    o_addr = '0; o_wdata = '0; o_err = 0; o_da = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b0;
      if (stall) o_sc++;
      if (mem_req) begin
        o_rc++;
        if (o_rc == 1) begin
          o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
        end else if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_wdata) begin
          o_unst = 1;
        end
        if (o_rc == ack_dly) begin
          mem_ack = 1'b1;
          if (mem_we) resp_mem[mem_addr] = mem_wdata;
          else mem_rdata = resp_rd(mem_addr);
        end
      end
      if (done) begin
        o_dc = c; o_err = dmem_error;
        if (spur) begin mem_ack = 1'b1; mem_rdata = JUNK; end
        break;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    o_da = done; o_valm = valM;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; icode = 0; valE = 0; valA = 0; valP = 0;
    mem_ack = 0; mem_rdata = 0; exp_valm = '0;
    repeat (3) @(negedge clk);
    total++; if ({stall, done, dmem_error, mem_req, mem_we} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {stall, done, dmem_error, mem_req, mem_we}); else passed++;
    total++; if ({valM, mem_addr, mem_wdata} !== 192'b0) $display("FAIL reset_data got %h/%h/%h exp 0", valM, mem_addr, mem_wdata); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({stall, done, mem_req} !== 3'b0) $display("FAIL reset_idle got %b exp 000", {stall, done, mem_req}); else passed++;
  endtask

  task automatic test_rmmovq;
    run_op(4'h4, 64'd12, 64'd3, 64'd0, 2, 0);
    ref_mem[64'd12] = 64'd3;
    total++; if (o_rc != 2) $display("FAIL rmmovq_req_cycles got %0d exp 2", o_rc); else passed++;
    total++; if (o_we !== 1'b1 || o_addr !== 64'd12 || o_wdata !== 64'd3) $display("FAIL rmmovq_fields got we=%0d addr=%0d wdata=%0d exp 1/12/3", o_we, o_addr, o_wdata); else passed++;
    total++; if (o_unst) $display("FAIL rmmovq_stable got unstable exp stable"); else passed++;
    total++; if (o_dc != 3 || o_err !== 1'b0) $display("FAIL rmmovq_done got cyc=%0d err=%0d exp 3/0", o_dc, o_err); else passed++;
    total++; if (o_da !== 1'b0) $display("FAIL rmmovq_done_pulse got %0d exp 0", o_da); else passed++;
  endtask

  task automatic test_mrmovq;
    resp_mem[64'd4] = 64'd2; ref_mem[64'd4] = 64'd2;
    run_op(4'h5, 64'd4, 64'd0, 64'd0, 1, 0);
    exp_valm = 64'd2;
    total++; if (o_valm !== 64'd2) $display("FAIL mrmovq_valm got %h exp 2", o_valm); else passed++;
    total++; if (o_dc != 2) $display("FAIL mrmovq_latency got %0d exp 2", o_dc); else passed++;
    total++; if (o_sc != 1) $display("FAIL mrmovq_stall got %0d exp 1", o_sc); else passed++;
    total++; if (o_we !== 1'b0 || o_addr !== 64'd4) $display("FAIL mrmovq_fields got we=%0d addr=%0d exp 0/4", o_we, o_addr); else passed++;
  endtask

  task automatic test_call_ret;
    run_op(4'h8, 64'd100, 64'h55, 64'h40, 1, 0);
    ref_mem[64'd100] = 64'h40;
    total++; if (o_we !== 1'b1 || o_addr !== 64'd100 || o_wdata !== 64'h40) $display("FAIL call_fields got we=%0d addr=%0d wdata=%h exp 1/100/40", o_we, o_addr, o_wdata); else passed++;
    run_op(4'h9, 64'h999, 64'd100, 64'd0, 3, 1);
    exp_valm = 64'h40;
    total++; if (o_we !== 1'b0 || o_addr !== 64'd100) $display("FAIL ret_fields got we=%0d addr=%0d exp 0/100", o_we, o_addr); else passed++;
    total++; if (o_valm !== 64'h40 || o_err !== 1'b0) $display("FAIL ret_valm got %h err=%0d exp 40/0", o_valm, o_err); else passed++;
  endtask

  task automatic test_out_of_range;
    run_op(4'hA, 64'd1024, 64'd5, 64'd0, 1, 0);
    total++; if (o_rc != 0 || o_sc != 0) $display("FAIL oob_no_req got req=%0d stall=%0d exp 0/0", o_rc, o_sc); else passed++;
    total++; if (o_dc != 1 || o_err !== 1'b1) $display("FAIL oob_error got cyc=%0d err=%0d exp 1/1", o_dc, o_err); else passed++;
    total++; if (dmem_error !== 1'b1) $display("FAIL oob_sticky got %0d exp 1", dmem_error); else passed++;
    run_op(4'h1, 64'd0, 64'd0, 64'd0, 1, 0);
    total++; if (o_dc != 1 || o_err !== 1'b0 || o_sc != 0) $display("FAIL nop_clear got cyc=%0d err=%0d stall=%0d exp 1/0/0", o_dc, o_err, o_sc); else passed++;
    total++; if (o_valm !== exp_valm) $display("FAIL nop_valm got %h exp %h", o_valm, exp_valm); else passed++;
    run_op(4'hB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    total++; if (o_rc != 0 || o_err !== 1'b1) $display("FAIL oob_huge got req=%0d err=%0d exp 0/1", o_rc, o_err); else passed++;
    run_op(4'hA, 64'd1023, 64'h1234, 64'd0, 1, 0);
    ref_mem[64'd1023] = 64'h1234;
    total++; if (o_rc != 1 || o_err !== 1'b0 || o_addr !== 64'd1023) $display("FAIL edge_1023 got req=%0d err=%0d addr=%0d exp 1/0/1023", o_rc, o_err, o_addr); else passed++;
  endtask

  task automatic test_timeout;
    run_op(4'hB, 64'd0, 64'd8, 64'd0, 0, 0);
    total++; if (o_rc != TIMEOUT || o_sc != TIMEOUT) $display("FAIL timeout_req got req=%0d stall=%0d exp %0d", o_rc, o_sc, TIMEOUT); else passed++;
    total++; if (o_dc != TIMEOUT + 1 || o_err !== 1'b1) $display("FAIL timeout_err got cyc=%0d err=%0d exp %0d/1", o_dc, o_err, TIMEOUT + 1); else passed++;
    total++; if (o_valm !== exp_valm) $display("FAIL timeout_valm got %h exp %h", o_valm, exp_valm); else passed++;
    run_op(4'hB, 64'd0, 64'd8, 64'd0, TIMEOUT, 0);
    exp_valm = ref_rd(64'd8);
    total++; if (o_rc != TIMEOUT || o_dc != TIMEOUT + 1 || o_err !== 1'b0) $display("FAIL late_ack got req=%0d cyc=%0d err=%0d exp %0d/%0d/0", o_rc, o_dc, o_err, TIMEOUT, TIMEOUT + 1); else passed++;
    total++; if (o_valm !== exp_valm) $display("FAIL late_ack_valm got %h exp %h", o_valm, exp_valm); else passed++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; icode = 4'h5; valE = 64'd7;
    @(negedge clk);
    start = 1'b0;
    total++; if (mem_req !== 1'b1 || stall !== 1'b1) $display("FAIL mid_pre got req=%0d stall=%0d exp 1/1", mem_req, stall); else passed++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_req, stall, done, dmem_error} !== 4'b0 || valM !== 64'd0) $display("FAIL mid_reset got req=%0d stall=%0d done=%0d err=%0d valM=%h exp 0", mem_req, stall, done, dmem_error, valM); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_valm = '0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      logic [3:0]  ic;
      logic [63:0] ve, va, vp, a, wd;
      int          ack, kind, e_dc, e_rc;
      bit          spur, e_err;
      ic   = 4'($urandom_range(0, 15));
      ve   = pick_addr();
      va   = pick_addr();
      vp   = {32'($urandom), 32'($urandom)};
      ack  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      spur = 1'($urandom_range(0, 1));
      kind = ref_kind(ic);
      a    = ref_addr(ic, ve, va);
      wd   = ref_wdata(ic, va, vp);
      e_rc = 0; e_dc = 1; e_err = 0;
      if (kind != 0 && a >= 64'(MEM_WORDS)) begin
        e_err = 1;
      end else if (kind != 0) begin
        e_rc = (ack == 0) ? TIMEOUT : ack;
        e_dc = e_rc + 1;
        e_err = (ack == 0);
        if (ack != 0 && kind == 1) exp_valm = ref_rd(a);
        if (ack != 0 && kind == 2) ref_mem[a] = wd;
      end
      run_op(ic, ve, va, vp, ack, spur);
      total++; if (o_dc != e_dc || o_da !== 1'b0) $display("FAIL rnd%0d_done got cyc=%0d after=%0d exp %0d/0", i, o_dc, o_da, e_dc); else passed++;
      total++; if (o_rc != e_rc || o_sc != e_rc) $display("FAIL rnd%0d_req got req=%0d stall=%0d exp %0d", i, o_rc, o_sc, e_rc); else passed++;
      total++; if (o_err !== e_err) $display("FAIL rnd%0d_err got %0d exp %0d", i, o_err, e_err); else passed++;
      total++; if (o_valm !== exp_valm) $display("FAIL rnd%0d_valm got %h exp %h", i, o_valm, exp_valm); else passed++;
      if (e_rc != 0) begin
        total++; if (o_we !== (kind == 2) || o_addr !== a || o_unst) $display("FAIL rnd%0d_fields got we=%0d addr=%h unst=%0d exp %0d/%h/0", i, o_we, o_addr, o_unst, kind == 2, a); else passed++;
        if (kind == 2) begin
          total++; if (o_wdata !== wd) $display("FAIL rnd%0d_wdata got %h exp %h", i, o_wdata, wd); else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rmmovq();
    test_mrmovq();
    test_call_ret();
    test_out_of_range();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_requester.md
Name: dmem_requester

Overview:
- Initiator side of the Y86 data-memory interface.
- Sits between the execute/memory stage and a multi-cycle data memory with a req/ack handshake.
- Decodes icode into a read or write, picks the address and write data, and issues one request per instruction.
- Holds the stage stalled until the memory acks, then returns valM, or flags an address or timeout error.

Parameters:
- MEM_WORDS, 1024, number of addressable 64-bit words; valid word addresses are 0..MEM_WORDS-1.
- TIMEOUT, 16, max cycles to wait for mem_ack before raising dmem_error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: instruction is present in the memory stage.
- icode  in  4  instruction code.
- valE  in  64  ALU result (address for mrmovq/rmmovq/call/pushq).
- valA  in  64  register operand (write data; address for ret/popq).
- valP  in  64  next PC (write data for call).
- stall  out  1  high while a request is outstanding.
- done  out  1  one-cycle pulse: access complete; valM/dmem_error valid.
- valM  out  64  read data.
- dmem_error  out  1  address out of range or ack timeout; sticky until next start.
- mem_req  out  1  request valid to memory.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  64  word address.
- mem_wdata  out  64  write data.
- mem_ack  in  1  memory accepted/completed request (one cycle).
- mem_rdata  in  64  read data, valid when mem_ack=1 on a read.

Behaviour:
- Reset (async, rst_n=0): state IDLE; stall=0, done=0, valM=0, dmem_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; timeout counter=0.
- Decode, registered on start:
  - 0x5 mrmovq: read valE.
  - 0x4 rmmovq: write valA to valE.
  - 0x8 call: write valP to valE.
  - 0xA pushq: write valA to valE.
  - 0x9 ret: read valA.
  - 0xB popq: read valA.
  - Any other icode: no access.
- IDLE:
  - start with no-access icode: done=1 next cycle, stall stays 0, valM unchanged, dmem_error=0.
  - start with access icode and address >= MEM_WORDS (unsigned 64-bit compare): go to DONE with dmem_error=1; no mem_req is issued.
  - start with access icode, valid address: go to REQ; mem_req/mem_we/mem_addr/mem_wdata registered; stall=1 from the next cycle.
- REQ:
  - mem_req held high with stable addr/we/wdata until mem_ack.
  - Timeout counter increments each cycle in REQ.
  - mem_ack=1: drop mem_req the same edge; on a read, latch valM=mem_rdata; go to DONE.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req, dmem_error=1, go to DONE.
- DONE: done=1 for exactly one cycle, stall=0, then return to IDLE.
- Latency: ack in the first REQ cycle gives done 2 cycles after start.
- Writes leave valM unchanged.
- start while not IDLE is ignored; the upstream stage is stalled and must not assert it.
- mem_ack while in IDLE or DONE is ignored.
- mem_ack arriving on the timeout cycle: the ack wins and there is no error.
- Reset mid-request: mem_req drops immediately (async); the memory must tolerate an abandoned request.
- dmem_error is cleared on the next accepted start.

Decomposition:
- Shared package y86_pkg holds:
  - icode localparams: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - FSM state enum: IDLE, REQ, DONE.
  - Status code STAT_ADR for downstream use.
- One natural sub-module: dmem_decode, combinational icode -> {access, we, addr_sel, wdata_sel}. Keep the FSM in the top.

Test Plan:
- rmmovq: icode=4, valE=12, valA=3, ack after 2 cycles -> mem_req=1 with mem_we=1, addr=12, wdata=3 held 2 cycles; done pulse; dmem_error=0.
- mrmovq: icode=5, valE=4, memory acks with rdata=2 in the first REQ cycle -> valM=2, done 2 cycles after start, stall high exactly 1 cycle.
- call then ret: icode=8 with valE=100, valP=0x40 writes 0x40 at 100; icode=9 with valA=100, rdata=0x40 -> valM=0x40.
- Out of range: icode=A, valE=1024 -> no mem_req ever, done with dmem_error=1; next start with icode=1 clears the error, done next cycle, no stall.
- Timeout: icode=B, valA=8, mem_ack never asserted -> mem_req high 16 cycles then low, dmem_error=1, done pulse; repeat with ack on cycle 16 -> no error.
- Reset: assert rst_n=0 while in REQ -> mem_req, stall, done, valM go to 0 immediately, without waiting for a clock edge.
